// File: rtl/row_slot_scheduler_pkg.sv
// Shared types and sizing helpers for the row slot scheduler and its delay stage.
package row_slot_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SLOT,
        ST_IDLEGAP,
        ST_FLUSHWAIT,
        ST_DONE
    } state_t;

    localparam int SIZE_DEF       = 28;
    localparam int GAP_DEF        = 0;
    localparam int PADWAIT_DEF    = 21;
    localparam int ROW_PERIOD_DEF = PADWAIT_DEF + (SIZE_DEF + 2) * (1 + GAP_DEF);

    function automatic int clog2_slots(input int size);
        return $clog2(size + 2);
    endfunction

    function automatic int row_period(input int size, input int gap, input int padwait);
        return padwait + (size + 2) * (1 + gap);
    endfunction

endpackage

// File: rtl/row_slot_scheduler_slot_delay_reg.sv
// Moves the slot-timeline strobes one cycle later to line up with FIFO read data.
// Latency 1 cycle; no backpressure.
module row_slot_scheduler_slot_delay_reg #(
    parameter int CW = 5
) (
    input  logic          i_clk,
    input  logic          i_rdreq,
    input  logic          i_hsync,
    input  logic [CW-1:0] i_col,
    input  logic          i_reuse,
    output logic          o_valid,
    output logic          o_hsync,
    output logic [CW-1:0] o_col,
    output logic          o_reuse
);
    logic          r_valid;
    logic          r_hsync;
    logic [CW-1:0] r_col;
    logic          r_reuse;

    // No reset here: the inputs are already cleared by reset, so this stage
    // drains one cycle later and keeps the delayed timeline honest on aborts.
    always_ff @(posedge i_clk) begin
        r_valid <= i_rdreq;
        r_hsync <= i_hsync;
        r_col   <= i_col;
        r_reuse <= i_reuse;
    end

    assign o_valid = r_valid;
    assign o_hsync = r_hsync;
    assign o_col   = r_col;
    assign o_reuse = r_reuse;

endmodule

// File: rtl/row_slot_scheduler.sv
// Row-stage timing controller: pad wait, padded slot playout with gaps, row queueing, flush row.
// Latency PADWAIT+1 cycles from row pulse to slot 0; no backpressure, excess pulses set o_ovf.
module row_slot_scheduler
    import row_slot_scheduler_pkg::*;
#(
    parameter int SIZE     = 28,
    parameter int GAP      = 0,
    parameter int PADWAIT  = 21,
    parameter int PEND_MAX = 3
) (
    input  logic                         i_sclk,
    input  logic                         i_vsync,
    input  logic                         i_hsync,
    output logic                         o_rdreq,
    output logic                         o_vsync,
    output logic                         o_hsync,
    output logic                         o_reuse,
    output logic                         o_valid,
    output logic [clog2_slots(SIZE)-1:0] o_col,
    output logic                         o_busy,
    output logic                         o_ovf
);
    localparam int CW = clog2_slots(SIZE);
    localparam int WW = (PADWAIT > 0) ? $clog2(PADWAIT + 1) : 1;
    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int RW = $clog2(SIZE + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(SIZE + 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(PADWAIT);
    localparam logic [3:0]    GAP_INIT  = 4'(GAP);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);
    localparam logic [RW-1:0] ROW_LAST  = RW'(SIZE - 1);

    state_t        r_state, w_state_n;
    logic [WW-1:0] r_wcnt,  w_wcnt_n;
    logic [CW-1:0] r_col,   w_col_n;
    logic [3:0]    r_gcnt,  w_gcnt_n;
    logic [PW-1:0] r_pend,  w_pend_n;
    logic [RW-1:0] r_row,   w_row_n;
    logic          r_flush, w_flush_n;
    logic          r_ovf,   w_ovf_n;
    logic          r_rdreq, r_shsync, r_sreuse, r_busy, r_vsync;
    logic          w_slot_done, w_row_end, w_hs_taken;
    logic          w_slot_n, w_rdreq_n, w_shsync_n, w_sreuse_n, w_busy_n;

    function automatic state_t wait_or_slot(input state_t wait_st);
        return (PADWAIT == 0) ? ST_SLOT : wait_st;
    endfunction

    always_comb begin
        w_state_n   = r_state;
        w_wcnt_n    = r_wcnt;
        w_col_n     = r_col;
        w_gcnt_n    = r_gcnt;
        w_pend_n    = r_pend;
        w_row_n     = r_row;
        w_flush_n   = r_flush;
        w_ovf_n     = r_ovf;
        w_slot_done = 1'b0;
        w_row_end   = 1'b0;
        w_hs_taken  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_hsync) begin
                    w_hs_taken = 1'b1;
                    w_state_n  = wait_or_slot(ST_WAIT);
                    w_wcnt_n   = WAIT_INIT;
                    w_col_n    = '0;
                end
            end
            ST_WAIT, ST_FLUSHWAIT: begin
                if (r_wcnt == WW'(1)) begin
                    w_state_n = ST_SLOT;
                    w_col_n   = '0;
                end else begin
                    w_wcnt_n = r_wcnt - 1'b1;
                end
            end
            ST_SLOT: begin
                if (GAP > 0) begin
                    w_state_n = ST_IDLEGAP;
                    w_gcnt_n  = GAP_INIT;
                end else begin
                    w_slot_done = 1'b1;
                end
            end
            ST_IDLEGAP: begin
                if (r_gcnt == 4'd1) begin
                    w_slot_done = 1'b1;
                end else begin
                    w_gcnt_n = r_gcnt - 1'b1;
                end
            end
            ST_DONE: begin
                if (i_hsync) begin
                    w_ovf_n = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        if (w_slot_done) begin
            if (r_col == COL_LAST) begin
                w_row_end = 1'b1;
            end else begin
                w_state_n = ST_SLOT;
                w_col_n   = r_col + 1'b1;
            end
        end

        if (w_row_end) begin
            if (r_flush) begin
                w_state_n = ST_DONE;
                w_flush_n = 1'b0;
            end else if (r_row == ROW_LAST) begin
                w_row_n   = r_row + 1'b1;
                w_flush_n = 1'b1;
                w_state_n = wait_or_slot(ST_FLUSHWAIT);
                w_wcnt_n  = WAIT_INIT;
                w_col_n   = '0;
            end else begin
                w_row_n = r_row + 1'b1;
                // A pulse landing on the decision cycle starts the next row directly.
                if (i_hsync || (r_pend != '0)) begin
                    w_state_n = wait_or_slot(ST_WAIT);
                    w_wcnt_n  = WAIT_INIT;
                    w_col_n   = '0;
                    if (i_hsync) begin
                        w_hs_taken = 1'b1;
                    end else begin
                        w_pend_n = r_pend - 1'b1;
                    end
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
        end

        if (i_hsync && !w_hs_taken && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
            if (r_pend == PEND_FULL) begin
                w_ovf_n = 1'b1;
            end else begin
                w_pend_n = r_pend + 1'b1;
            end
        end
    end

    // Slot-timeline outputs are decoded from the next state so they register in-slot.
    assign w_slot_n   = (w_state_n == ST_SLOT);
    assign w_rdreq_n  = w_slot_n && !w_flush_n && (w_col_n != '0) && (w_col_n != COL_LAST);
    assign w_shsync_n = w_slot_n && (w_col_n == '0);
    assign w_sreuse_n = w_slot_n && w_flush_n;
    assign w_busy_n   = (w_state_n != ST_IDLE) && (w_state_n != ST_DONE);

    always_ff @(posedge i_sclk) begin
        r_vsync <= i_vsync;
        if (i_vsync) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= '0;
            r_col    <= '0;
            r_gcnt   <= '0;
            r_pend   <= '0;
            r_row    <= '0;
            r_flush  <= 1'b0;
            r_ovf    <= 1'b0;
            r_rdreq  <= 1'b0;
            r_shsync <= 1'b0;
            r_sreuse <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_wcnt   <= w_wcnt_n;
            r_col    <= w_col_n;
            r_gcnt   <= w_gcnt_n;
            r_pend   <= w_pend_n;
            r_row    <= w_row_n;
            r_flush  <= w_flush_n;
            r_ovf    <= w_ovf_n;
            r_rdreq  <= w_rdreq_n;
            r_shsync <= w_shsync_n;
            r_sreuse <= w_sreuse_n;
            r_busy   <= w_busy_n;
        end
    end

    row_slot_scheduler_slot_delay_reg #(
        .CW (CW)
    ) u_slot_delay (
        .i_clk   (i_sclk),
        .i_rdreq (r_rdreq),
        .i_hsync (r_shsync),
        .i_col   (r_col),
        .i_reuse (r_sreuse),
        .o_valid (o_valid),
        .o_hsync (o_hsync),
        .o_col   (o_col),
        .o_reuse (o_reuse)
    );

    assign o_rdreq = r_rdreq;
    assign o_vsync = r_vsync;
    assign o_busy  = r_busy;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_row_slot_scheduler.sv
// Scoreboard bench: expected output events queued by stimulus, popped by a negedge monitor.
module tb_row_slot_scheduler;

    typedef struct {
        int cyc;
        bit rd;
        bit va;
        bit hs;
        bit ru;
        int col;
    } ev_t;

    logic clk = 1'b0;
    logic i_vsync = 1'b1;
    logic i_hsync = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;

    ev_t  exp_q[$];
    ev_t  mon_e;
    bit   ev_rd[256];
    bit   ev_va[256];
    bit   ev_hs[256];
    bit   ev_ru[256];
    int   ev_col[256];

    logic       a_rdreq, a_vsync, a_hsync, a_reuse, a_valid, a_busy, a_ovf;
    logic [2:0] a_col;
    logic       z_rdreq, z_vsync, z_hsync, z_reuse, z_valid, z_busy, z_ovf;
    logic [2:0] z_col;
    logic       m_rd, m_va, m_hs, m_ru;
    logic [2:0] m_col;

    row_slot_scheduler #(.SIZE(4), .GAP(1), .PADWAIT(2), .PEND_MAX(3)) u_dut (
        .i_sclk (clk),     .i_vsync(i_vsync), .i_hsync(i_hsync),
        .o_rdreq(a_rdreq), .o_vsync(a_vsync), .o_hsync(a_hsync),
        .o_reuse(a_reuse), .o_valid(a_valid), .o_col  (a_col),
        .o_busy (a_busy),  .o_ovf  (a_ovf)
    );

    row_slot_scheduler #(.SIZE(4), .GAP(0), .PADWAIT(0), .PEND_MAX(3)) u_dut_zero (
        .i_sclk (clk),     .i_vsync(i_vsync), .i_hsync(i_hsync),
        .o_rdreq(z_rdreq), .o_vsync(z_vsync), .o_hsync(z_hsync),
        .o_reuse(z_reuse), .o_valid(z_valid), .o_col  (z_col),
        .o_busy (z_busy),  .o_ovf  (z_ovf)
    );

    assign m_rd  = sel ? z_rdreq : a_rdreq;
    assign m_va  = sel ? z_valid : a_valid;
    assign m_hs  = sel ? z_hsync : a_hsync;
    assign m_ru  = sel ? z_reuse : a_reuse;
    assign m_col = sel ? z_col   : a_col;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_rd || m_va || m_hs || m_ru) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event rel=%0d got rd=%0b va=%0b hs=%0b ru=%0b col=%0d, none expected",
                         cyc - base, m_rd, m_va, m_hs, m_ru, m_col);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.rd != m_rd || mon_e.va != m_va || mon_e.hs != m_hs ||
                    mon_e.ru != m_ru || ((mon_e.va || mon_e.hs || mon_e.ru) && mon_e.col != int'(m_col))) begin
                    errors++;
                    $display("FAIL event got rel=%0d rd=%0b va=%0b hs=%0b ru=%0b col=%0d, want rel=%0d rd=%0b va=%0b hs=%0b ru=%0b col=%0d",
                             cyc - base, m_rd, m_va, m_hs, m_ru, m_col,
                             mon_e.cyc - base, mon_e.rd, mon_e.va, mon_e.hs, mon_e.ru, mon_e.col);
                end
            end
        end
    end

    task automatic at_cyc(input int rel);
        while (cyc < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check1(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s rel=%0d: got %0d, want %0d", name, cyc - base, act, exp);
        end
    endtask

    task automatic do_reset();
        i_vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_vsync = 1'b0;
        base = cyc;
    endtask

    task automatic pulse(input int rel);
        at_cyc(rel);
        i_hsync = 1'b1;
        at_cyc(rel + 1);
        i_hsync = 1'b0;
    endtask

    task automatic clear_ev();
        for (int i = 0; i < 256; i++) begin
            ev_rd[i] = 1'b0; ev_va[i] = 1'b0; ev_hs[i] = 1'b0; ev_ru[i] = 1'b0; ev_col[i] = 0;
        end
    endtask

    // Events of one padded row whose slot 0 is at relative cycle s0; a reset
    // sampled at cycle rst suppresses slot strobes after rst and delayed ones after rst+1.
    task automatic add_row(input int s0, input int size, input int gap, input bit flush, input int rst);
        int sc;
        int dc;
        bit data;
        for (int c = 0; c < size + 2; c++) begin
            sc = s0 + c * (1 + gap);
            dc = sc + 1;
            data = (c >= 1) && (c <= size);
            if (data && !flush && sc <= rst && sc < 256) ev_rd[sc] = 1'b1;
            if (dc <= rst + 1 && dc < 256) begin
                if (c == 0) ev_hs[dc] = 1'b1;
                if (data && !flush) ev_va[dc] = 1'b1;
                if (flush) ev_ru[dc] = 1'b1;
                ev_col[dc] = c;
            end
        end
    endtask

    task automatic commit_ev();
        ev_t e;
        for (int i = 0; i < 256; i++) begin
            if (ev_rd[i] || ev_va[i] || ev_hs[i] || ev_ru[i]) begin
                e.cyc = base + i; e.rd = ev_rd[i]; e.va = ev_va[i];
                e.hs = ev_hs[i];  e.ru = ev_ru[i]; e.col = ev_col[i];
                exp_q.push_back(e);
            end
        end
    endtask

    localparam int NONE = 100000;

    initial begin
        // Basic row plus reset state
        do_reset();
        clear_ev(); add_row(13, 4, 1, 0, NONE); commit_ev();
        at_cyc(0);  check1("vsync_follow_hi", a_vsync, 1);
        at_cyc(1);  check1("vsync_follow_lo", a_vsync, 0);
        check1("rst_busy", a_busy, 0); check1("rst_ovf", a_ovf, 0); check1("rst_rdreq", a_rdreq, 0);
        at_cyc(2);  check1("rst_valid", a_valid, 0); check1("rst_col", a_col, 0);
        check1("rst_hsync", a_hsync, 0); check1("rst_reuse", a_reuse, 0);
        pulse(10);
        at_cyc(11); check1("busy_in_wait", a_busy, 1);
        at_cyc(24); check1("right_pad_col", a_col, 5); check1("busy_last_gap", a_busy, 1);
        at_cyc(25); check1("idle_after_row", a_busy, 0);
        at_cyc(30); check1("basic_queue_empty", exp_q.size(), 0);

        // Back-to-back rows queued while busy
        do_reset();
        clear_ev(); add_row(13, 4, 1, 0, NONE); add_row(27, 4, 1, 0, NONE); add_row(41, 4, 1, 0, NONE); commit_ev();
        pulse(10); pulse(12); pulse(14);
        at_cyc(52); check1("b2b_busy_end", a_busy, 1);
        at_cyc(53); check1("b2b_idle", a_busy, 0);
        at_cyc(55); check1("b2b_no_ovf", a_ovf, 0);
        at_cyc(60); check1("b2b_queue_empty", exp_q.size(), 0);

        // Frame end: four real rows then a flush row, then DONE rejects pulses
        do_reset();
        clear_ev();
        add_row(13, 4, 1, 0, NONE); add_row(27, 4, 1, 0, NONE);
        add_row(41, 4, 1, 0, NONE); add_row(55, 4, 1, 0, NONE);
        add_row(69, 4, 1, 1, NONE);
        commit_ev();
        pulse(10); pulse(12); pulse(14); pulse(16);
        at_cyc(70); check1("flush_busy", a_busy, 1);
        at_cyc(85); check1("done_not_busy", a_busy, 0); check1("done_no_ovf", a_ovf, 0);
        pulse(90);
        at_cyc(92); check1("done_pulse_ovf", a_ovf, 1);
        at_cyc(95); check1("frame_queue_empty", exp_q.size(), 0);

        // Overflow: fifth pulse while busy is dropped; sticky until vsync
        do_reset();
        clear_ev(); add_row(13, 4, 1, 0, NONE); add_row(27, 4, 1, 0, 30); commit_ev();
        pulse(10); pulse(12); pulse(14); pulse(16);
        at_cyc(18); check1("ovf_before_drop", a_ovf, 0);
        pulse(18);
        at_cyc(19); check1("ovf_set", a_ovf, 1);
        at_cyc(25); check1("ovf_sticky", a_ovf, 1);
        at_cyc(30); i_vsync = 1'b1;
        at_cyc(31); i_vsync = 1'b0;
        check1("ovf_rst_vsync", a_vsync, 1); check1("ovf_rst_busy", a_busy, 0); check1("ovf_rst_rdreq", a_rdreq, 0);
        at_cyc(32); check1("ovf_cleared", a_ovf, 0); check1("ovf_rst_valid", a_valid, 0);
        at_cyc(40); check1("ovf_queue_empty", exp_q.size(), 0);

        // Reset in slot 2, then a clean row afterwards
        do_reset();
        clear_ev(); add_row(13, 4, 1, 0, 17); add_row(28, 4, 1, 0, NONE); commit_ev();
        pulse(10);
        at_cyc(17); i_vsync = 1'b1;
        at_cyc(18); i_vsync = 1'b0;
        check1("mid_rdreq_off", a_rdreq, 0); check1("mid_valid_tail", a_valid, 1);
        check1("mid_vsync", a_vsync, 1);     check1("mid_busy", a_busy, 0);
        at_cyc(19); check1("mid_valid_off", a_valid, 0);
        pulse(25);
        at_cyc(45); check1("mid_queue_empty", exp_q.size(), 0);

        // Zero GAP / PADWAIT, with a pulse on the row-end decision cycle
        do_reset();
        sel = 1'b1;
        clear_ev(); add_row(6, 4, 0, 0, NONE); add_row(12, 4, 0, 0, NONE); commit_ev();
        pulse(5);
        pulse(11);
        at_cyc(12); check1("zero_restart_busy", z_busy, 1);
        at_cyc(18); check1("zero_idle", z_busy, 0); check1("zero_no_ovf", z_ovf, 0);
        at_cyc(25); check1("zero_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
